// File: rtl/cpu_run_ctrl.sv
// Run controller in front of the CPU: holds reset, pulses req, counts cycles to done.
// Optional watchdog enabled by defining CPU_RUN_CTRL_TIMEOUT_EN.
module cpu_run_ctrl #(
    parameter int            CW         = 16,
    parameter int            RST_CYCLES = 2,
    parameter logic [CW-1:0] TO_LIMIT   = 16'd5000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cpu_done,
    output logic          cpu_reset,
    output logic          cpu_req,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        REQ,
        RUN,
        FIN,
        TOUT
    } state_t;

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    rst_cnt_q;
    logic [3:0]    rst_cnt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          to_hit;

    assign to_hit      = WD_EN && (cnt_q == TO_LIMIT);
    assign cycle_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE, FIN, TOUT: begin
                if (start) begin
                    state_d   = CRST;
                    rst_cnt_d = '0;
                    cnt_d     = '0;
                end
            end
            CRST: begin
                rst_cnt_d = rst_cnt_q + 4'd1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = RUN;
            end
            RUN: begin
                // done has priority over the watchdog in the same cycle
                if (cpu_done) begin
                    state_d = FIN;
                end else if (to_hit) begin
                    state_d = TOUT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            cpu_reset <= 1'b1;
            cpu_req   <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            cpu_reset <= (state_d == IDLE) || (state_d == CRST) ||
                         (state_d == FIN) || (state_d == TOUT);
            cpu_req   <= (state_d == REQ);
            busy      <= (state_d == CRST) || (state_d == REQ) ||
                         (state_d == RUN);
            finished  <= (state_d == FIN);
        end
    end

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= (state_d == TOUT);
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized self-checking bench for cpu_run_ctrl against a timeline model.
module tb_cpu_run_ctrl;

    localparam int CW  = 4;
    localparam int R   = 2;
    localparam int TL  = 10;
    localparam int MAX = 15;
`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          cpu_done;
    logic          cpu_reset;
    logic          cpu_req;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    int n_chk;
    int n_pass;

    cpu_run_ctrl #(
        .CW(CW),
        .RST_CYCLES(R),
        .TO_LIMIT(4'd10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cpu_done(cpu_done),
        .cpu_reset(cpu_reset),
        .cpu_req(cpu_req),
        .busy(busy),
        .finished(finished),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last RUN cycle index for a run whose done arrives on RUN cycle d
    function automatic int last_run(input int d);
        if (WD && (d - 1 > TL)) return TL + 1;
        return d;
    endfunction

    // Expected {cpu_reset,req,busy,fin,tout,count} t cycles after the start sample
    function automatic logic [8:0] model(input int t, input int d);
        int k;
        int c;
        if (t <= R) return {5'b10100, 4'd0};
        if (t == R + 1) return {5'b01100, 4'd0};
        k = t - R - 1;
        if (k <= last_run(d)) begin
            c = (k - 1 > MAX) ? MAX : k - 1;
            return {5'b00100, 4'(c)};
        end
        if (WD && (d - 1 > TL)) return {5'b10001, 4'(TL)};
        c = (d - 1 > MAX) ? MAX : d - 1;
        return {5'b10010, 4'(c)};
    endfunction

    // One run from a start sample; caller sits at a negedge
    task automatic run_one(input int d, input bit hold,
                           input bit noise_hi, input int post);
        int lastk;
        int last_t;
        int k;
        logic [8:0] got;
        logic [8:0] exp;
        lastk  = last_run(d);
        last_t = R + 2 + lastk;
        start  = 1'b1;
        for (int t = 1; t <= last_t + post; t++) begin
            @(negedge clk);
            got = {cpu_reset, cpu_req, busy, finished, timeout, cycle_count};
            exp = model(t, d);
            n_chk++;
            if (got !== exp)
                $display("FAIL run d=%0d t=%0d got=%b exp=%b", d, t, got, exp);
            else
                n_pass++;
            k = t - R - 1;
            if (k >= 1 && k <= lastk)
                cpu_done = (k == d);
            else
                cpu_done = noise_hi ? 1'b1 : 1'($urandom_range(1));
            if (hold)
                start = 1'b1;
            else if (t < last_t)
                start = 1'($urandom_range(1));
            else
                start = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b0;
        cpu_done = 1'b0;
        #2 reset = 1'b0;
        #2;
        n_chk++;
        if ({cpu_reset, cpu_req, busy, finished, timeout, cycle_count} !== 9'b10000_0000)
            $display("FAIL reset_async got=%b exp=100000000",
                     {cpu_reset, cpu_req, busy, finished, timeout, cycle_count});
        else
            n_pass++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_reset, busy, cycle_count} !== 6'b10_0000)
            $display("FAIL reset_hold got=%b exp=100000", {cpu_reset, busy, cycle_count});
        else
            n_pass++;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({cpu_reset, cpu_req, busy, finished, timeout} !== 5'b10000)
            $display("FAIL reset_idle got=%b exp=10000",
                     {cpu_reset, cpu_req, busy, finished, timeout});
        else
            n_pass++;
    endtask

    task automatic test_start_defaults;
        run_one(3, 1'b0, 1'b0, 1);
    endtask

    task automatic test_normal_run;
        run_one(6, 1'b0, 1'b0, 2);
    endtask

    task automatic test_spurious_done;
        cpu_done = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, finished, cycle_count} !== {2'b01, 4'd5})
            $display("FAIL stale_done_fin got=%b exp=010101", {busy, finished, cycle_count});
        else
            n_pass++;
        run_one(1, 1'b0, 1'b1, 1);
        cpu_done = 1'b0;
    endtask

    task automatic test_busy_restart;
        run_one(8, 1'b0, 1'b0, 2);
        run_one(2, 1'b0, 1'b0, 1);
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1;
        for (int t = 1; t <= R + 4; t++) begin
            @(negedge clk);
            start    = 1'b0;
            cpu_done = 1'b0;
        end
        n_chk++;
        if ({busy, cycle_count} !== {1'b1, 4'd2})
            $display("FAIL mid_run_pre got=%b exp=10010", {busy, cycle_count});
        else
            n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({cpu_reset, cpu_req, busy, finished, timeout, cycle_count} !== 9'b10000_0000)
            $display("FAIL mid_run_reset got=%b exp=100000000",
                     {cpu_reset, cpu_req, busy, finished, timeout, cycle_count});
        else
            n_pass++;
        @(negedge clk);
        reset    = 1'b1;
        cpu_done = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cpu_reset, busy, finished, timeout} !== 4'b1000)
            $display("FAIL mid_run_idle got=%b exp=1000", {cpu_reset, busy, finished, timeout});
        else
            n_pass++;
        cpu_done = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_one(4, 1'b1, 1'b0, 0);
        run_one(2, 1'b1, 1'b0, 0);
        run_one(3, 1'b0, 1'b0, 2);
    endtask

    task automatic test_watchdog;
        run_one(30, 1'b0, 1'b0, 2);
        run_one(TL + 1, 1'b0, 1'b0, 2);
        run_one(TL, 1'b0, 1'b0, 1);
    endtask

    task automatic test_random;
        int d;
        bit hold;
        for (int i = 0; i < 20; i++) begin
            d    = $urandom_range(1, 22);
            hold = 1'($urandom_range(1));
            run_one(d, hold, 1'b0, hold ? 0 : $urandom_range(0, 3));
        end
        run_one(2, 1'b0, 1'b0, 1);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_start_defaults();
        test_normal_run();
        test_spurious_done();
        test_busy_restart();
        test_reset_mid_run();
        test_back_to_back();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
